// File: rtl/touch_key_cond_pkg.sv
// Shared definitions for the touch-key conditioner: click FSM states and default counts.
package touch_key_cond_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HOLD  = 3'd1,
    ST_LONG  = 3'd2,
    ST_WAIT2 = 3'd3,
    ST_HOLD2 = 3'd4
  } state_t;

  localparam int unsigned      DEF_CNT_W        = 25;
  localparam logic [24:0]      DEF_DEBOUNCE_CNT = 25'd1_000_000;
  localparam logic [24:0]      DEF_LONG_CNT     = 25'd25_000_000;
  localparam logic [24:0]      DEF_DOUBLE_GAP   = 25'd12_500_000;

endpackage

// File: rtl/touch_key_cond_if.sv
// Touch-key signal bundle: raw sensor in, debounced level and event strobes out.
interface touch_key_cond_if;
  logic touch_key;
  logic key_level;
  logic press_pulse;
  logic release_pulse;
  logic click_single;
  logic click_double;
  logic long_press;

  modport master (
    output touch_key,
    input  key_level, press_pulse, release_pulse, click_single, click_double, long_press
  );

  modport slave (
    input  touch_key,
    output key_level, press_pulse, release_pulse, click_single, click_double, long_press
  );
endinterface

// File: rtl/touch_key_cond_key_debounce.sv
// Two-flop synchroniser, stability counter and one-cycle edge strobes for the touch key.
module touch_key_cond_key_debounce #(
  parameter int unsigned      CNT_W        = 25,
  parameter logic [CNT_W-1:0] DEBOUNCE_CNT = 25'd1_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic touch_key,
  output logic key_level,
  output logic press_pulse,
  output logic release_pulse
);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] db_cnt;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync_p0       <= 1'b0;
      sync_p1       <= 1'b0;
      db_cnt        <= '0;
      key_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      // synchroniser stage boundary
      sync_p0       <= touch_key;
      sync_p1       <= sync_p0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      // any agreement with the current level restarts the stability window
      if (sync_p1 == key_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DEBOUNCE_CNT - 1'b1) begin
        db_cnt        <= '0;
        key_level     <= sync_p1;
        press_pulse   <= sync_p1;
        release_pulse <= ~sync_p1;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/touch_key_cond.sv
// Touch-key conditioner top: debounce plus click/long-press FSM with hold and gap counters.
// Define TOUCH_DBL_CLICK_EN to build double-click detection (delays click_single by the gap).
module touch_key_cond
  import touch_key_cond_pkg::*;
#(
  parameter int unsigned      CNT_W        = DEF_CNT_W,
  parameter logic [CNT_W-1:0] DEBOUNCE_CNT = DEF_DEBOUNCE_CNT,
  parameter logic [CNT_W-1:0] LONG_CNT     = DEF_LONG_CNT,
  parameter logic [CNT_W-1:0] DOUBLE_GAP   = DEF_DOUBLE_GAP
) (
  input logic              sys_clk,
  input logic              sys_rst,
  touch_key_cond_if.slave  kif
);

  state_t           state, state_nx;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_nx;
  logic             single_nx, long_nx;
`ifdef TOUCH_DBL_CLICK_EN
  logic [CNT_W-1:0] gap_cnt, gap_cnt_nx;
  logic             double_nx;
`endif

  touch_key_cond_key_debounce #(
    .CNT_W        (CNT_W),
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
  ) u_key_debounce (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .touch_key     (kif.touch_key),
    .key_level     (kif.key_level),
    .press_pulse   (kif.press_pulse),
    .release_pulse (kif.release_pulse)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state            <= ST_IDLE;
      hold_cnt         <= '0;
      kif.click_single <= 1'b0;
      kif.long_press   <= 1'b0;
`ifdef TOUCH_DBL_CLICK_EN
      gap_cnt          <= '0;
      kif.click_double <= 1'b0;
`endif
    end else begin
      state            <= state_nx;
      hold_cnt         <= hold_cnt_nx;
      kif.click_single <= single_nx;
      kif.long_press   <= long_nx;
`ifdef TOUCH_DBL_CLICK_EN
      gap_cnt          <= gap_cnt_nx;
      kif.click_double <= double_nx;
`endif
    end
  end

`ifndef TOUCH_DBL_CLICK_EN
  assign kif.click_double = 1'b0;
`endif

  // Release is tested before hold expiry and press before gap expiry, so ties favour clicks.
  always_comb begin
    state_nx    = state;
    hold_cnt_nx = hold_cnt;
    single_nx   = 1'b0;
    long_nx     = 1'b0;
`ifdef TOUCH_DBL_CLICK_EN
    gap_cnt_nx  = gap_cnt;
    double_nx   = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (kif.press_pulse) begin
          state_nx    = ST_HOLD;
          hold_cnt_nx = '0;
        end
      end
      ST_HOLD: begin
        hold_cnt_nx = hold_cnt + 1'b1;
        if (kif.release_pulse) begin
`ifdef TOUCH_DBL_CLICK_EN
          state_nx   = ST_WAIT2;
          gap_cnt_nx = '0;
`else
          state_nx  = ST_IDLE;
          single_nx = 1'b1;
`endif
        end else if (hold_cnt == LONG_CNT - 1'b1) begin
          state_nx = ST_LONG;
          long_nx  = 1'b1;
        end
      end
      ST_LONG: begin
        if (kif.release_pulse) state_nx = ST_IDLE;
      end
`ifdef TOUCH_DBL_CLICK_EN
      ST_WAIT2: begin
        gap_cnt_nx = gap_cnt + 1'b1;
        if (kif.press_pulse) begin
          state_nx    = ST_HOLD2;
          hold_cnt_nx = '0;
        end else if (gap_cnt == DOUBLE_GAP - 1'b1) begin
          state_nx  = ST_IDLE;
          single_nx = 1'b1;
        end
      end
      ST_HOLD2: begin
        hold_cnt_nx = hold_cnt + 1'b1;
        if (kif.release_pulse) begin
          state_nx  = ST_IDLE;
          double_nx = 1'b1;
        end else if (hold_cnt == LONG_CNT - 1'b1) begin
          state_nx = ST_LONG;
          long_nx  = 1'b1;
        end
      end
`endif
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule
